// File: rtl/instr_decode_stage.sv
// Registered MIPS instruction decode stage: valid/ready input, 2-entry FIFO of decoded entries, flush.
// Optional macro LOGIC_ZEXT_EN: andi/ori/xori zero-extend their immediate instead of sign-extending.
module instr_decode_stage #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [5:0]        out_opcode,
  output logic [5:0]        out_funct,
  output logic [4:0]        out_rs,
  output logic [4:0]        out_rt,
  output logic [4:0]        out_rd,
  output logic [4:0]        out_shamt,
  output logic [DATA_W-1:0] out_imm_ext,
  output logic [PC_W-1:0]   out_jtarget,
  output logic [PC_W-1:0]   out_pc,
  output logic [1:0]        out_type
);

  localparam logic [1:0] TYPE_R = 2'b00;
  localparam logic [1:0] TYPE_I = 2'b01;
  localparam logic [1:0] TYPE_J = 2'b10;

  typedef struct packed {
    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        shamt;
    logic [DATA_W-1:0] imm_ext;
    logic [PC_W-1:0]   jtarget;
    logic [PC_W-1:0]   pc;
    logic [1:0]        itype;
  } entry_t;

  function automatic entry_t decode(input logic [31:0] instr, input logic [PC_W-1:0] pc);
    entry_t          e;
    logic [PC_W-1:0] pc4;
    e.opcode = instr[31:26];
    e.funct  = instr[5:0];
    e.rs     = instr[25:21];
    e.rt     = instr[20:16];
    e.rd     = instr[15:11];
    e.shamt  = instr[10:6];
    e.pc     = pc;
`ifdef LOGIC_ZEXT_EN
    if (instr[31:26] == 6'h0C || instr[31:26] == 6'h0D || instr[31:26] == 6'h0E)
      e.imm_ext = DATA_W'(instr[15:0]);
    else
      e.imm_ext = DATA_W'($signed(instr[15:0]));
`else
    e.imm_ext = DATA_W'($signed(instr[15:0]));
`endif
    // Upper PC bits come from pc+4; the low 28 bits are overwritten by the target field.
    pc4           = pc + PC_W'(4);
    e.jtarget     = pc4;
    e.jtarget[27:0] = {instr[25:0], 2'b00};
    if (instr[31:26] == 6'h00)
      e.itype = TYPE_R;
    else if (instr[31:26] == 6'h02 || instr[31:26] == 6'h03)
      e.itype = TYPE_J;
    else
      e.itype = TYPE_I;
    return e;
  endfunction

  entry_t     mem_q [2];
  logic [1:0] count_q, count_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic       live_q;
  logic       push, pop;
  entry_t     head;

  assign in_ready  = live_q && (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      // Keep the read pointer so the head outputs hold their last values.
      count_d  = 2'd0;
      wr_ptr_d = rd_ptr_q;
    end else begin
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      live_q   <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      live_q   <= 1'b1;
      if (push) mem_q[wr_ptr_q] <= decode(in_instr, in_pc);
    end
  end

  assign head        = mem_q[rd_ptr_q];
  assign out_opcode  = head.opcode;
  assign out_funct   = head.funct;
  assign out_rs      = head.rs;
  assign out_rt      = head.rt;
  assign out_rd      = head.rd;
  assign out_shamt   = head.shamt;
  assign out_imm_ext = head.imm_ext;
  assign out_jtarget = head.jtarget;
  assign out_pc      = head.pc;
  assign out_type    = head.itype;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed, table-driven bench for instr_decode_stage (default 32-bit parameters).
module tb_instr_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_instr, in_pc;
  logic [5:0]  out_opcode, out_funct;
  logic [4:0]  out_rs, out_rt, out_rd, out_shamt;
  logic [31:0] out_imm_ext, out_jtarget, out_pc;
  logic [1:0]  out_type;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  instr_decode_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_funct(out_funct), .out_rs(out_rs), .out_rt(out_rt),
    .out_rd(out_rd), .out_shamt(out_shamt), .out_imm_ext(out_imm_ext),
    .out_jtarget(out_jtarget), .out_pc(out_pc), .out_type(out_type)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [31:0] imm;
    logic [31:0] jt;
    logic [1:0]  typ;
  } vec_t;

  vec_t vecs[9];

  function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] pc,
                              input logic [5:0] op, input logic [5:0] funct,
                              input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] rd, input logic [4:0] shamt,
                              input logic [31:0] imm, input logic [31:0] jt,
                              input logic [1:0] typ);
    vec_t v;
    v.instr = instr; v.pc = pc; v.op = op; v.funct = funct;
    v.rs = rs; v.rt = rt; v.rd = rd; v.shamt = shamt;
    v.imm = imm; v.jt = jt; v.typ = typ;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_head(input string tag, input vec_t v);
    chk({tag, ".valid"},  32'(out_valid),   32'd1);
    chk({tag, ".opcode"}, 32'(out_opcode),  32'(v.op));
    chk({tag, ".funct"},  32'(out_funct),   32'(v.funct));
    chk({tag, ".rs"},     32'(out_rs),      32'(v.rs));
    chk({tag, ".rt"},     32'(out_rt),      32'(v.rt));
    chk({tag, ".rd"},     32'(out_rd),      32'(v.rd));
    chk({tag, ".shamt"},  32'(out_shamt),   32'(v.shamt));
    chk({tag, ".imm"},    out_imm_ext,      v.imm);
    chk({tag, ".jt"},     out_jtarget,      v.jt);
    chk({tag, ".pc"},     out_pc,           v.pc);
    chk({tag, ".type"},   32'(out_type),    32'(v.typ));
  endtask

  // All stimulus changes happen 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input vec_t v);
    in_valid = 1'b1;
    in_instr = v.instr;
    in_pc    = v.pc;
  endtask

  initial begin
    logic [31:0] ori_imm, andi_imm;
`ifdef LOGIC_ZEXT_EN
    ori_imm  = 32'h0000FFFF;
    andi_imm = 32'h00008000;
`else
    ori_imm  = 32'hFFFFFFFF;
    andi_imm = 32'hFFFF8000;
`endif
    vecs[0] = mk(32'h00851020, 32'h00400000, 6'h00, 6'h20, 5'd4, 5'd5, 5'd2, 5'd0,
                 32'h00001020, 32'h02144080, 2'b00);
    vecs[1] = mk(32'h2002FFFF, 32'h00400004, 6'h08, 6'h3F, 5'd0, 5'd2, 5'd31, 5'd31,
                 32'hFFFFFFFF, 32'h000BFFFC, 2'b01);
    vecs[2] = mk(32'h3442FFFF, 32'h00400008, 6'h0D, 6'h3F, 5'd2, 5'd2, 5'd31, 5'd31,
                 ori_imm, 32'h010BFFFC, 2'b01);
    vecs[3] = mk(32'h08000010, 32'h00400000, 6'h02, 6'h10, 5'd0, 5'd0, 5'd0, 5'd0,
                 32'h00000010, 32'h00000040, 2'b10);
    vecs[4] = mk(32'h08000010, 32'hF0000000, 6'h02, 6'h10, 5'd0, 5'd0, 5'd0, 5'd0,
                 32'h00000010, 32'hF0000040, 2'b10);
    vecs[5] = mk(32'h0C000001, 32'hFFFFFFFC, 6'h03, 6'h01, 5'd0, 5'd0, 5'd0, 5'd0,
                 32'h00000001, 32'h00000004, 2'b10);
    vecs[6] = mk(32'h30238000, 32'h10000000, 6'h0C, 6'h00, 5'd1, 5'd3, 5'd16, 5'd0,
                 andi_imm, 32'h108E0000, 2'b01);
    vecs[7] = mk(32'h8CA48000, 32'h00000000, 6'h23, 6'h00, 5'd5, 5'd4, 5'd16, 5'd0,
                 32'hFFFF8000, 32'h02920000, 2'b01);
    vecs[8] = mk(32'h00041080, 32'h00000000, 6'h00, 6'h00, 5'd0, 5'd4, 5'd2, 5'd2,
                 32'h00001080, 32'h00104200, 2'b00);

    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    flush = 1'b0; out_ready = 1'b0;

    // Reset held 3 cycles
    repeat (3) step();
    chk("rst.in_ready",  32'(in_ready),  32'd0);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.opcode",    32'(out_opcode), 32'd0);
    chk("rst.rs",        32'(out_rs),    32'd0);
    chk("rst.imm",       out_imm_ext,    32'd0);
    chk("rst.jt",        out_jtarget,    32'd0);
    chk("rst.pc",        out_pc,         32'd0);
    chk("rst.type",      32'(out_type),  32'd0);
    rst_n = 1'b1;
    step();
    chk("rel.in_ready",  32'(in_ready),  32'd1);
    chk("rel.out_valid", 32'(out_valid), 32'd0);

    // Table: one instruction at a time through an empty FIFO
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      offer(vecs[i]);
      step();
      in_valid = 1'b0;
      chk_head($sformatf("vec%0d", i), vecs[i]);
      step();
      chk($sformatf("vec%0d.drained", i), 32'(out_valid), 32'd0);
    end

    // Back-pressure: three back-to-back offers with the consumer stalled
    out_ready = 1'b0;
    offer(vecs[0]);
    step();
    chk("bp.ready1", 32'(in_ready), 32'd1);
    chk_head("bp.head1", vecs[0]);
    offer(vecs[1]);
    step();
    chk("bp.ready2", 32'(in_ready), 32'd0);
    offer(vecs[2]);
    step();
    chk("bp.ready3", 32'(in_ready), 32'd0);
    chk_head("bp.stall", vecs[0]);
    step();
    chk_head("bp.stall2", vecs[0]);
    out_ready = 1'b1;
    step();
    chk_head("bp.drain2", vecs[1]);
    chk("bp.ready_after_pop", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk_head("bp.drain3", vecs[2]);
    step();
    chk("bp.empty", 32'(out_valid), 32'd0);

    // Flush with 2 entries buffered and an input offered
    out_ready = 1'b0;
    offer(vecs[3]);
    step();
    offer(vecs[4]);
    step();
    chk("fl2.full", 32'(in_ready), 32'd0);
    offer(vecs[5]);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl2.out_valid", 32'(out_valid), 32'd0);
    chk("fl2.in_ready",  32'(in_ready),  32'd1);
    step();
    chk("fl2.still_empty", 32'(out_valid), 32'd0);

    // Flush with 1 entry while an input would otherwise be accepted
    offer(vecs[6]);
    step();
    offer(vecs[7]);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl1.out_valid", 32'(out_valid), 32'd0);
    chk("fl1.in_ready",  32'(in_ready),  32'd1);
    step();
    chk("fl1.dropped", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    offer(vecs[8]);
    step();
    in_valid = 1'b0;
    chk_head("fl1.next", vecs[8]);
    step();
    chk("fl1.drained", 32'(out_valid), 32'd0);

    // Reset mid-operation
    out_ready = 1'b0;
    offer(vecs[4]);
    step();
    in_valid = 1'b0;
    chk("mid.valid_before", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    step();
    chk("mid.out_valid", 32'(out_valid), 32'd0);
    chk("mid.in_ready",  32'(in_ready),  32'd0);
    chk("mid.pc",        out_pc,         32'd0);
    chk("mid.jt",        out_jtarget,    32'd0);
    chk("mid.type",      32'(out_type),  32'd0);
    rst_n = 1'b1;
    step();
    chk("mid.rel_ready", 32'(in_ready),  32'd1);
    chk("mid.rel_valid", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
